// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// The optional bne support (macro MCU_BNE_EN) uses OP_BNE from here.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mcu_alu_decoder.sv
// Maps an ALU-op class (add / sub / funct-driven) plus the funct field
// to the 3-bit ALU control code; unknown functs fall back to add.
module mcu_alu_decoder
  import mcu_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int ALUCW = 3
) (
  input  aluop_t           alu_op,
  input  logic [OPW-1:0]   funct,
  output logic [ALUCW-1:0] alu_control
);

  // ALU operation select from class and funct field.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes per-cycle controls. Macro MCU_BNE_EN adds bne.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int ALUCW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALUCW-1:0] alu_control,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal_op
);

  state_t           state_r;
  state_t           state_next_s;
  aluop_t           alu_op_s;
  logic             alu_en_s;
  logic [ALUCW-1:0] alu_dec_s;
  logic             is_bne_s;

`ifdef MCU_BNE_EN
  logic is_bne_r;

  // Remember at decode whether the branch in flight is bne.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_bne_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      is_bne_r <= (opcode == OP_BNE);
    end else begin
      is_bne_r <= is_bne_r;
    end
  end

  assign is_bne_s = is_bne_r;
`else
  assign is_bne_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control decode; everything stays low while rst is high.
  always_comb begin
    state_next_s = S_FETCH;
    alu_op_s     = ALUOP_ADD;
    alu_en_s     = 1'b0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    pc_src       = PCSRC_ALU;
    pc_en        = 1'b0;
    illegal_op   = 1'b0;
    if (rst) begin
      state_next_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_en_s  = 1'b1;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_en        = 1'b1;
            state_next_s = S_DECODE;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_en_s  = 1'b1;
          case (opcode)
            OP_LW, OP_SW: state_next_s = S_MEMADR;
            OP_RTYPE:     state_next_s = S_EXECUTE;
            OP_BEQ:       state_next_s = S_BRANCH;
`ifdef MCU_BNE_EN
            OP_BNE:       state_next_s = S_BRANCH;
`endif
            OP_ADDI:      state_next_s = S_ADDIEX;
            OP_J:         state_next_s = S_JUMP;
            default: begin
              illegal_op   = 1'b1;
              state_next_s = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_en_s  = 1'b1;
          if (opcode == OP_LW) begin
            state_next_s = S_MEMREAD;
          end else if (opcode == OP_SW) begin
            state_next_s = S_MEMWRITE;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_MEMREAD: begin
          mem_req      = 1'b1;
          iord         = 1'b1;
          state_next_s = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req      = 1'b1;
          mem_write    = 1'b1;
          iord         = 1'b1;
          state_next_s = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECUTE: begin
          alu_src_a    = 1'b1;
          alu_op_s     = ALUOP_FUNCT;
          alu_en_s     = 1'b1;
          state_next_s = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op_s  = ALUOP_SUB;
          alu_en_s  = 1'b1;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = zero ^ is_bne_s;
        end
        S_ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = SRCB_IMM;
          alu_en_s     = 1'b1;
          state_next_s = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
        end
        S_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
        default: state_next_s = S_FETCH;
      endcase
    end
  end

  mcu_alu_decoder #(
    .OPW   (OPW),
    .ALUCW (ALUCW)
  ) u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct       (funct),
    .alu_control (alu_dec_s)
  );

  assign alu_control = alu_en_s ? alu_dec_s : {ALUCW{1'b0}};

endmodule
